ifu_fill_unit: RTL and testbench
================================

IFU_FILL_UNIT -- requirements
Module: ifu_fill_unit

Interface
REQ-001 Parameter ADDR_WIDTH, 32: byte address width.
REQ-002 Parameter OFFSET_WIDTH, 4: line-offset bits; TAG_WIDTH = ADDR_WIDTH-OFFSET_WIDTH, derived, not overridable.
REQ-003 Parameter LINE_WIDTH, 128: cache line width in bits.
REQ-004 Parameter MEM_DATA_WIDTH, 32: memory beat width; BEATS = LINE_WIDTH/MEM_DATA_WIDTH, must be an integer >= 2.
REQ-005 Parameter TIMEOUT_CYCLES, 64: watchdog limit (used only under REQ-032).
REQ-006 Clock  in  1  single clock; all state rising-edge.
REQ-007 Rst  in  1  asynchronous, active-low reset.
REQ-008 miss_tag_in  in  TAG_WIDTH  tag requested by the cache.
REQ-009 miss_valid_in  in  1  cache miss request, level-held by the cache until the line is filled.
REQ-010 fill_tag_out  out  TAG_WIDTH  tag of the returned line.
REQ-011 fill_line_out  out  LINE_WIDTH  assembled line.
REQ-012 fill_valid_out  out  1  one-cycle fill pulse to the cache.
REQ-013 mem_req_valid_out  out  1  memory read request valid.
REQ-014 mem_req_ready_in  in  1  memory accepts the request.
REQ-015 mem_req_addr_out  out  ADDR_WIDTH  line-aligned address {tag, OFFSET_WIDTH zeros}.
REQ-016 mem_rsp_valid_in  in  1  one data beat valid.
REQ-017 mem_rsp_data_in  in  MEM_DATA_WIDTH  beat data, lowest beat first.
REQ-018 busy_out  out  1  high in any state other than IDLE.
REQ-019 fill_error_out  out  1  one-cycle abort pulse (constant 0 without REQ-032).

Function
REQ-020 FSM states: IDLE, REQ, FILL, RSP; at most one miss outstanding.
REQ-021 IDLE: miss_valid_in=1 -> capture miss_tag_in into a tag register, go to REQ next cycle; miss_valid_in ignored in every other state.
REQ-022 REQ: mem_req_valid_out=1, mem_req_addr_out from the captured tag, held stable until the cycle mem_req_ready_in=1; then -> FILL and clear the beat counter.
REQ-023 FILL: each cycle with mem_rsp_valid_in=1 writes the beat into line slice [k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], k = beat counter, then increments the counter; beats never arrive before the request handshake.
REQ-024 When the beat with k=BEATS-1 is accepted -> RSP next cycle; the counter is $clog2(BEATS) bits wide and never wraps inside a fill.
REQ-025 RSP: fill_valid_out=1 for exactly one cycle with fill_tag_out = captured tag and fill_line_out = assembled line; -> IDLE next cycle.
REQ-026 First IDLE after RSP: miss_valid_in sampled normally; a persisting miss (new tag, or same tag not yet inserted) starts a new fill. Minimum miss-to-fill latency = 3 + BEATS cycles with ready and beats back-to-back.
REQ-027 A change of miss_tag_in or a drop of miss_valid_in during REQ/FILL does not abort; the captured tag is still returned (the cache discards a mismatched tag).
REQ-028 fill_tag_out/fill_line_out hold their last values outside RSP; only fill_valid_out qualifies them.
REQ-029 mem_rsp_valid_in outside FILL is ignored.

Reset
REQ-030 Rst low asserts immediately, regardless of Clock: state=IDLE, beat counter=0, tag and line registers=0, all outputs 0 (fill_valid_out, mem_req_valid_out, busy_out, fill_error_out, mem_req_addr_out, fill_tag_out, fill_line_out).
REQ-031 Reset mid-fill abandons the fill with no fill_valid_out pulse; beats after reset release in IDLE are ignored per REQ-029.

Configuration
REQ-032 Macro IFU_FILL_TIMEOUT_EN defined: a watchdog counts consecutive FILL cycles without mem_rsp_valid_in, cleared on every beat and on FILL entry; on reaching TIMEOUT_CYCLES -> IDLE, fill_error_out=1 for one cycle, no fill_valid_out pulse.
REQ-033 Macro undefined: no watchdog logic, FILL waits indefinitely, fill_error_out tied 0.

Verification
REQ-034 Miss tag 0x0000123, ready same cycle, beats 0x11111111,0x22222222,0x33333333,0x44444444 back-to-back -> mem_req_addr_out=0x00001230, one pulse, fill_line_out=0x44444444_33333333_22222222_11111111, 7-cycle latency.
REQ-035 mem_req_ready_in held low 5 cycles -> mem_req_valid_out and address stable all 5 cycles; single request handshake.
REQ-036 Beats with 2-cycle gaps, miss_tag_in changed to 0x0000456 mid-FILL -> fill_tag_out=0x0000123, second miss accepted in the IDLE cycle after RSP.
REQ-037 Rst asserted after 2 of 4 beats -> all outputs 0 asynchronously, no fill pulse, later stray beats ignored.
REQ-038 IFU_FILL_TIMEOUT_EN, TIMEOUT_CYCLES=8, only 1 beat sent -> fill_error_out pulses 8 cycles after that beat, then IDLE; without the macro the FSM stays in FILL.

Source files
------------

// File: rtl/ifu_fill_unit.sv
// ifu_fill_unit: instruction-cache line fill engine.
// Captures one miss tag, issues a line-aligned memory read, assembles
// BEATS data beats (lowest beat first) into a line and returns it with a
// one-cycle fill pulse. Only one miss is outstanding at a time.
//
// Optional feature macro: IFU_FILL_TIMEOUT_EN
//   defined   -> FILL watchdog aborts a stalled fill after TIMEOUT_CYCLES
//                beat-less cycles and pulses fill_error_out.
//   undefined -> no watchdog, FILL waits indefinitely, fill_error_out = 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no miss in flight; samples miss_valid_in, captures the tag
// REQ   | memory read request presented, waiting for mem_req_ready_in
// FILL  | collecting beats into the line buffer
// RSP   | one-cycle fill pulse to the cache with captured tag + line
module ifu_fill_unit #(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int OFFSET_WIDTH   = 4,
  parameter  int LINE_WIDTH     = 128,
  parameter  int MEM_DATA_WIDTH = 32,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TAG_WIDTH-1:0]      miss_tag_in,
  input  logic                      miss_valid_in,
  output logic [TAG_WIDTH-1:0]      fill_tag_out,
  output logic [LINE_WIDTH-1:0]     fill_line_out,
  output logic                      fill_valid_out,
  output logic                      mem_req_valid_out,
  input  logic                      mem_req_ready_in,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_out,
  input  logic                      mem_rsp_valid_in,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_in,
  output logic                      busy_out,
  output logic                      fill_error_out
);

  localparam int BEATS  = LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit PARAMS_OK = (BEATS >= 2) && (LINE_WIDTH % MEM_DATA_WIDTH == 0) &&
                             (TIMEOUT_CYCLES >= 1) && (OFFSET_WIDTH < ADDR_WIDTH);

  // Reject parameter sets that cannot form a whole multi-beat line.
  if (!PARAMS_OK) begin : g_bad_params
    $error("ifu_fill_unit: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_RSP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [TAG_WIDTH-1:0]    fill_tag_q;
  logic [LINE_WIDTH-1:0]   fill_line_q;
  logic                    beat_acc;
  logic                    beat_last;
  logic                    req_hs;
  logic                    timeout;

  assign beat_acc  = (state_q == S_FILL) && mem_rsp_valid_in;
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign req_hs    = (state_q == S_REQ) && mem_req_ready_in;

`ifdef IFU_FILL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Watchdog down-counter: reloaded on FILL entry and on every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (req_hs || beat_acc) begin
      wdog_q <= WDOG_W'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == S_FILL) && (wdog_q != '0)) begin
      wdog_q <= wdog_q - 1'b1;
    end
  end

  assign timeout = (state_q == S_FILL) && !mem_rsp_valid_in && (wdog_q == '0);
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d           = state_q;
    mem_req_valid_out = 1'b0;
    fill_valid_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_valid_in) state_d = S_REQ;
      end
      S_REQ: begin
        mem_req_valid_out = 1'b1;
        if (mem_req_ready_in) state_d = S_FILL;
      end
      S_FILL: begin
        if (beat_acc && beat_last) state_d = S_RSP;
        else if (timeout)          state_d = S_IDLE;
      end
      S_RSP: begin
        fill_valid_out = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line buffer with the current beat merged into slice beat_q.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        line_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data_in;
      end
    end
  end

  // Miss tag capture, beat counter and line assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      beat_q <= '0;
      line_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && miss_valid_in) tag_q <= miss_tag_in;
      if (req_hs) begin
        beat_q <= '0;
      end else if (beat_acc) begin
        line_q <= line_d;
        beat_q <= beat_last ? '0 : beat_q + 1'b1;
      end
    end
  end

  // Returned tag/line are latched on the final beat so they stay put while
  // the next miss is being filled into line_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_tag_q  <= '0;
      fill_line_q <= '0;
    end else if (beat_acc && beat_last) begin
      fill_tag_q  <= tag_q;
      fill_line_q <= line_d;
    end
  end

  assign fill_tag_out     = fill_tag_q;
  assign fill_line_out    = fill_line_q;
  assign mem_req_addr_out = {tag_q, {OFFSET_WIDTH{1'b0}}};
  assign busy_out         = (state_q != S_IDLE);
  assign fill_error_out   = timeout;

endmodule

// File: tb/tb_ifu_fill_unit.sv
// Directed bench for ifu_fill_unit (default parameters, TIMEOUT_CYCLES=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ifu_fill_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [27:0]  miss_tag_in;
  logic         miss_valid_in;
  logic [27:0]  fill_tag_out;
  logic [127:0] fill_line_out;
  logic         fill_valid_out;
  logic         mem_req_valid_out;
  logic         mem_req_ready_in;
  logic [31:0]  mem_req_addr_out;
  logic         mem_rsp_valid_in;
  logic [31:0]  mem_rsp_data_in;
  logic         busy_out;
  logic         fill_error_out;

  int checks   = 0;
  int failures = 0;

  ifu_fill_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_tag_in       (miss_tag_in),
    .miss_valid_in     (miss_valid_in),
    .fill_tag_out      (fill_tag_out),
    .fill_line_out     (fill_line_out),
    .fill_valid_out    (fill_valid_out),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_rsp_valid_in  (mem_rsp_valid_in),
    .mem_rsp_data_in   (mem_rsp_data_in),
    .busy_out          (busy_out),
    .fill_error_out    (fill_error_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rsp_valid_in = 1'b1;
    mem_rsp_data_in  = d;
    tick();
    mem_rsp_valid_in = 1'b0;
    mem_rsp_data_in  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_fv"},    fill_valid_out, 0);
    chk({tag, "_rv"},    mem_req_valid_out, 0);
    chk({tag, "_err"},   fill_error_out, 0);
    chk({tag, "_addr"},  mem_req_addr_out, 0);
    chk({tag, "_ftag"},  fill_tag_out, 0);
    chk({tag, "_fline"}, fill_line_out, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    miss_tag_in      = '0;
    miss_valid_in    = 1'b0;
    mem_req_ready_in = 1'b0;
    mem_rsp_valid_in = 1'b0;
    mem_rsp_data_in  = '0;

    // Reset asserted before any clock edge.
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fill: ready same cycle, four back-to-back beats.
    miss_tag_in      = 28'h0000123;
    miss_valid_in    = 1'b1;
    mem_req_ready_in = 1'b1;
    chk("t1_idle_busy", busy_out, 0);
    tick();                                     // REQ
    chk("t1_req_valid", mem_req_valid_out, 1);
    chk("t1_req_addr",  mem_req_addr_out, 32'h0000_1230);
    chk("t1_req_busy",  busy_out, 1);
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    chk("t1_fill_noreq", mem_req_valid_out, 0);
    beat(32'h11111111);
    chk("t1_no_early_fv", fill_valid_out, 0);
    beat(32'h22222222);
    beat(32'h33333333);
    beat(32'h44444444);                         // RSP: 7th cycle counting the miss cycle
    miss_valid_in = 1'b0;
    chk("t1_fv",    fill_valid_out, 1);
    chk("t1_ftag",  fill_tag_out, 28'h0000123);
    chk("t1_fline", fill_line_out, 128'h44444444_33333333_22222222_11111111);
    tick();                                     // IDLE
    chk("t1_fv_once",   fill_valid_out, 0);
    chk("t1_idle_busy2", busy_out, 0);
    chk("t1_line_hold", fill_line_out, 128'h44444444_33333333_22222222_11111111);

    // Request held off by memory for 5 cycles.
    miss_tag_in   = 28'h0000ABC;
    miss_valid_in = 1'b1;
    tick();                                     // REQ
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_wait_valid%0d", i), mem_req_valid_out, 1);
      chk($sformatf("t2_wait_addr%0d", i),  mem_req_addr_out, 32'h0000_ABC0);
      tick();
    end
    mem_req_ready_in = 1'b1;
    chk("t2_hs_valid", mem_req_valid_out, 1);
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    chk("t2_single_req", mem_req_valid_out, 0);
    chk("t2_old_line_hold", fill_line_out, 128'h44444444_33333333_22222222_11111111);
    for (int i = 0; i < 4; i++) beat(32'hA0A0A0A0 + 32'(i));
    miss_valid_in = 1'b0;
    chk("t2_fv",    fill_valid_out, 1);
    chk("t2_ftag",  fill_tag_out, 28'h0000ABC);
    chk("t2_fline", fill_line_out, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);
    tick();

    // Gapped beats with the miss tag changing mid-fill; second miss follows.
    miss_tag_in      = 28'h0000123;
    miss_valid_in    = 1'b1;
    mem_req_ready_in = 1'b1;
    tick();                                     // REQ
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    beat(32'hC0000000);
    miss_tag_in = 28'h0000456;
    tick(); tick();
    beat(32'hC0000001);
    tick(); tick();
    beat(32'hC0000002);
    chk("t3_gap_busy", busy_out, 1);
    chk("t3_gap_fv",   fill_valid_out, 0);
    tick(); tick();
    beat(32'hC0000003);                         // RSP
    chk("t3_fv",    fill_valid_out, 1);
    chk("t3_ftag",  fill_tag_out, 28'h0000123);
    chk("t3_fline", fill_line_out, 128'hC0000003_C0000002_C0000001_C0000000);
    tick();                                     // IDLE, samples the pending miss
    chk("t3_idle_busy", busy_out, 0);
    tick();                                     // REQ for the new tag
    chk("t3_req2_valid", mem_req_valid_out, 1);
    chk("t3_req2_addr",  mem_req_addr_out, 32'h0000_4560);
    mem_req_ready_in = 1'b1;
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    miss_valid_in    = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'h5000_0000 + 32'(i));
    chk("t3_fv2",    fill_valid_out, 1);
    chk("t3_ftag2",  fill_tag_out, 28'h0000456);
    chk("t3_fline2", fill_line_out, 128'h50000003_50000002_50000001_50000000);
    tick();

    // Reset in the middle of a fill.
    miss_tag_in      = 28'h0000077;
    miss_valid_in    = 1'b1;
    mem_req_ready_in = 1'b1;
    tick();                                     // REQ
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    miss_valid_in    = 1'b0;
    beat(32'hBEEF0000);
    beat(32'hBEEF0001);
    chk("t4_pre_busy", busy_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t4_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(32'hDEAD0000);
    chk("t4_stray_busy", busy_out, 0);
    chk("t4_stray_fv",   fill_valid_out, 0);
    beat(32'hDEAD0001);
    chk("t4_stray_busy2", busy_out, 0);
    chk("t4_stray_line",  fill_line_out, 0);
    chk("t4_stray_fv2",   fill_valid_out, 0);

    // Stalled fill: a single beat, then silence.
    miss_tag_in      = 28'h0000055;
    miss_valid_in    = 1'b1;
    mem_req_ready_in = 1'b1;
    tick();                                     // REQ
    tick();                                     // FILL
    mem_req_ready_in = 1'b0;
    miss_valid_in    = 1'b0;
    beat(32'h12345678);                         // now 1 cycle after the beat
`ifdef IFU_FILL_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t5_wait_err%0d", i),  fill_error_out, 0);
      chk($sformatf("t5_wait_busy%0d", i), busy_out, 1);
      tick();
    end
    chk("t5_err_pulse", fill_error_out, 1);
    chk("t5_err_nofv",  fill_valid_out, 0);
    tick();
    chk("t5_err_once",  fill_error_out, 0);
    chk("t5_err_idle",  busy_out, 0);
    chk("t5_err_nofv2", fill_valid_out, 0);
`else
    for (int i = 1; i <= 20; i++) begin
      chk($sformatf("t5_stay_busy%0d", i), busy_out, 1);
      chk($sformatf("t5_no_err%0d", i),    fill_error_out, 0);
      tick();
    end
    chk("t5_stay_nofv", fill_valid_out, 0);
`endif

    rst_n = 1'b0;
    #1;
    chk("end_reset_busy", busy_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
